// File: rtl/mac_array_ctrl.sv
// rtl/mac_array_ctrl.sv - single-shot operand sequencer and result collector for a ROWS x COLS FP8 MAC grid
// Optional performance counters are enabled by defining MAC_CTRL_PERF_EN.
module mac_array_ctrl #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int TO_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_mode_fp8,
  input  logic [ROWS*8-1:0]        cmd_a,
  input  logic [COLS*8-1:0]        cmd_b,
  output logic                     arr_mode_fp8,
  output logic [ROWS*8-1:0]        arr_a_raw,
  output logic [ROWS-1:0]          arr_a_valid,
  output logic [COLS*8-1:0]        arr_b_raw,
  output logic [COLS-1:0]          arr_mac_valid,
  output logic                     arr_out_ready,
  input  logic [ROWS*COLS-1:0]     arr_done,
  input  logic [ROWS*COLS*16-1:0]  arr_res_bf,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ROWS*COLS*16-1:0]  rsp_tile,
  output logic                     rsp_err
`ifdef MAC_CTRL_PERF_EN
  ,
  output logic [31:0]              perf_ops,
  output logic [31:0]              perf_busy
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_SETTLE, S_RESP} state_t;

  localparam int KW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [KW-1:0]   K_LAST = KW'(COLS - 1);
  localparam logic [TO_W-1:0] TO_MAX = '1;
  localparam logic [TO_W-1:0] TO_LIM = TO_MAX - 1'b1;

  state_t                  state, state_nxt;
  logic [KW-1:0]           k;
  logic [TO_W-1:0]         to_cnt;
  logic                    ready_q;
  logic                    mode_q;
  logic [ROWS*8-1:0]       a_q;
  logic [(COLS-1)*8-1:0]   b_q;
  logic [COLS*8-1:0]       b_out;
  logic                    accept, timeout, rsp_fire;

  assign cmd_ready    = ready_q;
  assign arr_mode_fp8 = mode_q;
  assign arr_a_raw    = a_q;
  assign arr_b_raw    = b_out;
  assign rsp_valid    = (state == S_RESP);
  assign rsp_fire     = rsp_valid && rsp_ready;

  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    timeout       = 1'b0;
    arr_out_ready = 1'b0;
    arr_a_valid   = '0;
    arr_mac_valid = '0;
    case (state)
      S_IDLE: begin
        if (cmd_valid && ready_q) begin
          accept    = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        arr_mac_valid[k] = 1'b1;
        if (k == '0) arr_a_valid = '1;
        if (k == K_LAST) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (&arr_done) begin
          state_nxt = S_SETTLE;
        end else if (to_cnt == TO_LIM) begin
          timeout       = 1'b1;
          arr_out_ready = 1'b1;
          state_nxt     = S_RESP;
        end
      end
      S_SETTLE: begin
        arr_out_ready = 1'b1;
        state_nxt     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Column c's B is loaded one cycle ahead so it is on the bus exactly when A reaches column c.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ready_q  <= 1'b0;
      k        <= '0;
      to_cnt   <= '0;
      mode_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      b_out    <= '0;
      rsp_tile <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt == S_IDLE);
      if (accept) begin
        mode_q      <= cmd_mode_fp8;
        a_q         <= cmd_a;
        b_q         <= cmd_b[COLS*8-1:8];
        b_out[7:0]  <= cmd_b[7:0];
        k           <= '0;
      end
      if (state == S_ISSUE) begin
        k      <= k + 1'b1;
        to_cnt <= '0;
        for (int c = 1; c < COLS; c++) begin
          if (int'(k) == c - 1) b_out[8*c +: 8] <= b_q[8*(c-1) +: 8];
        end
      end else if (state == S_WAIT && to_cnt != TO_MAX) begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (state == S_SETTLE) rsp_tile <= arr_res_bf;
      if (timeout) rsp_err <= 1'b1;
      else if (rsp_fire) rsp_err <= 1'b0;
    end
  end

`ifdef MAC_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ops  <= '0;
      perf_busy <= '0;
    end else begin
      if (rsp_fire) perf_ops <= perf_ops + 32'd1;
      if (state != S_IDLE) perf_busy <= perf_busy + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mac_array_ctrl.sv
// tb/tb_mac_array_ctrl.sv - randomized self-checking bench for mac_array_ctrl with a behavioural MAC grid
// Perf-counter checks are compiled when MAC_CTRL_PERF_EN is defined.
module tb_mac_array_ctrl;
  localparam int ROWS = 4, COLS = 4, TO_W = 8, N = ROWS * COLS;

  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, cmd_mode_fp8 = 1'b0;
  logic [ROWS*8-1:0] cmd_a = '0;
  logic [COLS*8-1:0] cmd_b = '0;
  logic arr_mode_fp8, arr_out_ready, rsp_valid, rsp_err, rsp_ready = 1'b0;
  logic [ROWS*8-1:0] arr_a_raw;
  logic [ROWS-1:0] arr_a_valid;
  logic [COLS*8-1:0] arr_b_raw;
  logic [COLS-1:0] arr_mac_valid;
  logic [N-1:0] arr_done;
  logic [N*16-1:0] arr_res_bf, rsp_tile;
`ifdef MAC_CTRL_PERF_EN
  logic [31:0] perf_ops, perf_busy;
`endif

  always #5 clk = ~clk;

  mac_array_ctrl #(.ROWS(ROWS), .COLS(COLS), .TO_W(TO_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode_fp8(cmd_mode_fp8), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .arr_mode_fp8(arr_mode_fp8), .arr_a_raw(arr_a_raw), .arr_a_valid(arr_a_valid),
    .arr_b_raw(arr_b_raw), .arr_mac_valid(arr_mac_valid), .arr_out_ready(arr_out_ready),
    .arr_done(arr_done), .arr_res_bf(arr_res_bf), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_tile(rsp_tile), .rsp_err(rsp_err)
`ifdef MAC_CTRL_PERF_EN
    , .perf_ops(perf_ops), .perf_busy(perf_busy)
`endif
  );

  int total = 0, bad = 0;
  int op_cycles, last_busy, mode_bad, rel_cnt = 0, issue_cnt = 0;
  logic cur_mode;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic real fp8_val(input logic [7:0] v, input logic m);
    int e, mant;
    real f;
    if (m) begin
      e = int'(v[6:2]); mant = int'(v[1:0]);
      f = (1.0 + mant / 4.0) * (2.0 ** (e - 15));
    end else begin
      e = int'(v[6:3]); mant = int'(v[2:0]);
      f = (1.0 + mant / 8.0) * (2.0 ** (e - 7));
    end
    return v[7] ? -f : f;
  endfunction

  function automatic logic [15:0] to_bf16(input real x);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(x);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:45]};
  endfunction

  function automatic logic [7:0] rnd_fp8(input logic m);
    if (m) return {1'($urandom_range(0, 1)), 5'($urandom_range(1, 30)), 2'($urandom_range(0, 3))};
    return {1'($urandom_range(0, 1)), 4'($urandom_range(1, 14)), 3'($urandom_range(0, 7))};
  endfunction

  // Behavioural grid: A moves one column per cycle, done 2 cycles after valid, result 1 cycle after done.
  logic [N-1:0] done_q, pend_q, resv_q, done_mask = '0;
  logic [N*16-1:0] res_q;
  logic [15:0] val_q [N];
  logic [ROWS*8-1:0] a_stg [COLS];
  logic [ROWS-1:0] av_stg [COLS];

  assign arr_done   = done_q & ~done_mask;
  assign arr_res_bf = res_q;

  function automatic logic a_ok(input int r, input int c);
    if (c == 0) return arr_a_valid[r];
    return av_stg[c-1][r];
  endfunction

  function automatic logic [7:0] a_byte(input int r, input int c);
    if (c == 0) return arr_a_raw[8*r +: 8];
    return a_stg[c-1][8*r +: 8];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= '0; pend_q <= '0; resv_q <= '0; res_q <= '0;
      for (int c = 0; c < COLS; c++) begin a_stg[c] <= '0; av_stg[c] <= '0; end
    end else begin
      a_stg[0] <= arr_a_raw; av_stg[0] <= arr_a_valid;
      for (int c = 1; c < COLS; c++) begin a_stg[c] <= a_stg[c-1]; av_stg[c] <= av_stg[c-1]; end
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (arr_out_ready) begin
            done_q[r*COLS+c] <= 1'b0; pend_q[r*COLS+c] <= 1'b0; resv_q[r*COLS+c] <= 1'b0;
          end else if (arr_mac_valid[c]) begin
            pend_q[r*COLS+c] <= 1'b1;
            val_q[r*COLS+c] <= a_ok(r, c) ? to_bf16(fp8_val(a_byte(r, c), arr_mode_fp8) *
                               fp8_val(arr_b_raw[8*c +: 8], arr_mode_fp8)) : 16'hDEAD;
          end else if (pend_q[r*COLS+c]) begin
            pend_q[r*COLS+c] <= 1'b0; done_q[r*COLS+c] <= 1'b1;
          end else if (done_q[r*COLS+c] && !resv_q[r*COLS+c]) begin
            resv_q[r*COLS+c] <= 1'b1; res_q[16*(r*COLS+c) +: 16] <= val_q[r*COLS+c];
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    if (arr_out_ready) rel_cnt++;
    if (|arr_a_valid) issue_cnt++;
  end

  task automatic step();
    @(negedge clk);
    op_cycles++;
    if (arr_mode_fp8 !== cur_mode) mode_bad++;
  endtask

  task automatic run_cmd(input logic m, input logic [ROWS*8-1:0] a, input logic [COLS*8-1:0] b,
                         input int hold, input logic exp_err);
    logic [N*16-1:0] exp_tile;
    int n, lat, rel0, iss0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        exp_tile[16*(r*COLS+c) +: 16] = to_bf16(fp8_val(a[8*r +: 8], m) * fp8_val(b[8*c +: 8], m));
    @(negedge clk);
    cmd_mode_fp8 = m; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk("cmd_ready", cmd_ready, 1'b1);
    rel0 = rel_cnt; iss0 = issue_cnt; cur_mode = m; mode_bad = 0;
    @(negedge clk);
    cmd_valid = 1'b0; op_cycles = 1;
    for (int k = 0; k < COLS; k++) begin
      chk("mac_valid", arr_mac_valid, 1 << k);
      chk("a_valid", arr_a_valid, (k == 0) ? {ROWS{1'b1}} : '0);
      chk("b_raw", arr_b_raw[8*k +: 8], b[8*k +: 8]);
      if (k == 0) chk("a_raw", arr_a_raw, a);
      chk("cmd_ready_busy", cmd_ready, 1'b0);
      step();
    end
    lat = 0;
    while (!rsp_valid && lat < 400) begin step(); lat++; end
    chk("rsp_latency", lat, exp_err ? 255 : 3);
    chk("rsp_err", rsp_err, exp_err);
    if (!exp_err) chk("rsp_tile", rsp_tile, exp_tile);
    for (int i = 0; i < hold; i++) begin
      cmd_valid = (i == 3);
      chk("hold_valid", rsp_valid, 1'b1);
      chk("hold_ready", cmd_ready, 1'b0);
      if (!exp_err) chk("hold_tile", rsp_tile, exp_tile);
      step();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    last_busy = op_cycles;
    step();
    rsp_ready = 1'b0;
    chk("rsp_drop", rsp_valid, 1'b0);
    chk("idle_ready", cmd_ready, 1'b1);
    chk("err_clear", rsp_err, 1'b0);
    chk("release_once", rel_cnt - rel0, 1);
    chk("issue_once", issue_cnt - iss0, 1);
    chk("mode_stable", mode_bad, 0);
  endtask

  logic [ROWS*8-1:0] ra;
  logic [COLS*8-1:0] rb;
  logic rm;
  int ops0, busy0, bsum;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_tile", rsp_tile, '0);
    chk("rst_mac_valid", arr_mac_valid, '0);
    chk("rst_mode", arr_mode_fp8, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", cmd_ready, 1'b1);

    run_cmd(1'b0, {ROWS{8'h38}}, {COLS{8'h40}}, 0, 1'b0);
    chk("t1_tile", rsp_tile, {N{16'h4000}});
    run_cmd(1'b1, {ROWS{8'h3C}}, {COLS{8'hC0}}, 0, 1'b0);
    chk("t2_tile", rsp_tile, {N{16'hC000}});

    done_mask = N'(1) << 5;
    run_cmd(1'b0, {ROWS{8'h38}}, {COLS{8'h40}}, 0, 1'b1);
    done_mask = '0;
    run_cmd(1'b0, {ROWS{8'h40}}, {COLS{8'h38}}, 0, 1'b0);

    run_cmd(1'b1, {8'h3C, 8'h40, 8'h44, 8'hBC}, {8'h38, 8'hC4, 8'h3C, 8'h41}, 10, 1'b0);

    @(negedge clk);
    cmd_mode_fp8 = 1'b1; cmd_a = {ROWS{8'h3C}}; cmd_b = {COLS{8'h3C}}; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_issue2", arr_mac_valid, 4'b0100);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_mac_valid", arr_mac_valid, '0);
    chk("rst_mid_a_valid", arr_a_valid, '0);
    chk("rst_mid_rsp_valid", rsp_valid, 1'b0);
    chk("rst_mid_mode", arr_mode_fp8, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_mid_rst", cmd_ready, 1'b1);
    run_cmd(1'b0, {ROWS{8'h38}}, {8'h40, 8'h48, 8'hC0, 8'h30}, 0, 1'b0);

`ifdef MAC_CTRL_PERF_EN
    ops0 = int'(perf_ops); busy0 = int'(perf_busy); bsum = 0;
    for (int i = 0; i < 3; i++) begin
      run_cmd(1'b0, {ROWS{8'h38}}, {COLS{8'h40}}, 0, 1'b0);
      bsum += last_busy;
    end
    chk("perf_ops", int'(perf_ops) - ops0, 3);
    chk("perf_busy", int'(perf_busy) - busy0, bsum);
`endif

    for (int t = 0; t < 6; t++) begin
      rm = 1'($urandom_range(0, 1));
      for (int i = 0; i < ROWS; i++) ra[8*i +: 8] = rnd_fp8(rm);
      for (int i = 0; i < COLS; i++) rb[8*i +: 8] = rnd_fp8(rm);
      run_cmd(rm, ra, rb, int'($urandom_range(0, 2)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
